// File: rtl/writeback_stage.sv
// Writeback stage: retires one execute-stage result per cycle into the register file or data memory.
// MUL/DIV results take a second cycle to write their high byte to rd+1.
module writeback_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [4:0]  opcode,
    input  logic [2:0]  rd,
    input  logic [3:0]  mem_addr,
    input  logic [15:0] result,
    input  logic        zero_flag,
    input  logic        carry_flag,
    input  logic        ac_flag,
    input  logic        parity_flag,
    output logic        reg_we,
    output logic [2:0]  reg_waddr,
    output logic [7:0]  reg_wdata,
    output logic        mem_we,
    output logic [3:0]  mem_waddr,
    output logic [7:0]  mem_wdata,
    output logic [3:0]  flags_q,
    output logic        busy,
    output logic        halted,
    output logic        wb_done
);

    localparam int unsigned OP_W    = 5;
    localparam int unsigned RA_W    = 3;
    localparam int unsigned MA_W    = 4;
    localparam int unsigned RES_W   = 16;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned FLAGS_W = 4;

    localparam logic [OP_W-1:0] OP_MUL   = 5'b00011;
    localparam logic [OP_W-1:0] OP_DIV   = 5'b00100;
    localparam logic [OP_W-1:0] OP_STORE = 5'b01100;
    localparam logic [OP_W-1:0] OP_CMP   = 5'b11001;
    localparam logic [OP_W-1:0] OP_HALT  = 5'b11111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COMMIT = 2'd1,
        S_WR_HI  = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_reg_op(input logic [OP_W-1:0] op);
        return (op <= 5'b01011) || ((op >= 5'b10000) && (op <= 5'b10101));
    endfunction

    function automatic logic is_flag_op(input logic [OP_W-1:0] op);
        return ((op >= 5'b00001) && (op <= 5'b01010)) ||
               ((op >= 5'b10000) && (op <= 5'b10101)) || (op == OP_CMP);
    endfunction

    state_t               state_q, state_d;
    logic [OP_W-1:0]      op_q, op_d;
    logic [RA_W-1:0]      rd_q, rd_d;
    logic [MA_W-1:0]      addr_q, addr_d;
    logic [RES_W-1:0]     res_q, res_d;
    logic [FLAGS_W-1:0]   flg_q, flg_d;
    logic [FLAGS_W-1:0]   flags_d;
    logic                 accept;

    logic                 reg_we_d, mem_we_d, busy_d, halted_d, wb_done_d;
    logic [RA_W-1:0]      reg_waddr_d;
    logic [BYTE_W-1:0]    reg_wdata_d, mem_wdata_d;
    logic [MA_W-1:0]      mem_waddr_d;

    assign accept = enable && !busy;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_WR_HI: begin
                if (accept) state_d = (opcode == OP_HALT) ? S_HALT : S_COMMIT;
                else        state_d = S_IDLE;
            end
            S_COMMIT: begin
                if (is_muldiv(op_q)) state_d = S_WR_HI;
                else if (accept)     state_d = (opcode == OP_HALT) ? S_HALT : S_COMMIT;
                else                 state_d = S_IDLE;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Instruction latch and architectural flag update
    always_comb begin
        op_d    = op_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        res_d   = res_q;
        flg_d   = flg_q;
        flags_d = flags_q;
        if (accept) begin
            op_d   = opcode;
            rd_d   = rd;
            addr_d = mem_addr;
            res_d  = result;
            flg_d  = {zero_flag, carry_flag, ac_flag, parity_flag};
        end
        if ((state_q == S_COMMIT) && is_flag_op(op_q)) flags_d = flg_q;
    end

    // Outputs are decoded from the next state so they appear registered in that state
    always_comb begin
        reg_we_d    = 1'b0;
        reg_waddr_d = '0;
        reg_wdata_d = '0;
        mem_we_d    = 1'b0;
        mem_waddr_d = '0;
        mem_wdata_d = '0;
        busy_d      = 1'b0;
        halted_d    = 1'b0;
        wb_done_d   = 1'b0;
        unique case (state_d)
            S_COMMIT: begin
                busy_d    = is_muldiv(op_d);
                wb_done_d = !is_muldiv(op_d);
                if (op_d == OP_STORE) begin
                    mem_we_d    = 1'b1;
                    mem_waddr_d = addr_d;
                    mem_wdata_d = res_d[BYTE_W-1:0];
                end else if (is_reg_op(op_d)) begin
                    reg_we_d    = 1'b1;
                    reg_waddr_d = rd_d;
                    reg_wdata_d = res_d[BYTE_W-1:0];
                end
            end
            S_WR_HI: begin
                reg_we_d    = 1'b1;
                reg_waddr_d = RA_W'(rd_d + RA_W'(1));
                reg_wdata_d = res_d[RES_W-1:BYTE_W];
                wb_done_d   = 1'b1;
            end
            S_HALT: begin
                busy_d   = 1'b1;
                halted_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            rd_q      <= '0;
            addr_q    <= '0;
            res_q     <= '0;
            flg_q     <= '0;
            flags_q   <= '0;
            reg_we    <= 1'b0;
            reg_waddr <= '0;
            reg_wdata <= '0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            wb_done   <= 1'b0;
        end else begin
            op_q      <= op_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            res_q     <= res_d;
            flg_q     <= flg_d;
            flags_q   <= flags_d;
            reg_we    <= reg_we_d;
            reg_waddr <= reg_waddr_d;
            reg_wdata <= reg_wdata_d;
            mem_we    <= mem_we_d;
            mem_waddr <= mem_waddr_d;
            mem_wdata <= mem_wdata_d;
            busy      <= busy_d;
            halted    <= halted_d;
            wb_done   <= wb_done_d;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset, enable;
    logic [4:0]  opcode;
    logic [2:0]  rd;
    logic [3:0]  mem_addr;
    logic [15:0] result;
    logic        zero_flag, carry_flag, ac_flag, parity_flag;
    logic        reg_we, mem_we, busy, halted, wb_done;
    logic [2:0]  reg_waddr;
    logic [7:0]  reg_wdata, mem_wdata;
    logic [3:0]  mem_waddr, flags_q;

    int errors = 0;
    int checks = 0;

    writeback_stage dut (
        .clk(clk), .reset(reset), .enable(enable), .opcode(opcode), .rd(rd),
        .mem_addr(mem_addr), .result(result), .zero_flag(zero_flag),
        .carry_flag(carry_flag), .ac_flag(ac_flag), .parity_flag(parity_flag),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .flags_q(flags_q), .busy(busy), .halted(halted), .wb_done(wb_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [4:0] op, input logic [2:0] r,
                         input logic [3:0] ma, input logic [15:0] res, input logic [3:0] f);
        enable   = en;
        opcode   = op;
        rd       = r;
        mem_addr = ma;
        result   = res;
        {zero_flag, carry_flag, ac_flag, parity_flag} = f;
    endtask

    // Register/memory write port snapshot: {reg_we, waddr, wdata} and {mem_we, addr, data}
    task automatic check_ports(input string tag, input logic rwe, input logic [2:0] ra,
                               input logic [7:0] rdat, input logic mwe, input logic [3:0] ma,
                               input logic [7:0] mdat);
        check({tag, ".reg"}, {4'h0, rwe, ra, rdat}, {4'h0, rwe ? {rwe, ra, rdat} : 12'h000});
        check({tag, ".reg_port"}, {4'h0, reg_we, reg_waddr, reg_wdata}, {4'h0, rwe, ra, rdat});
        check({tag, ".mem_port"}, {3'h0, mem_we, mem_waddr, mem_wdata}, {3'h0, mwe, ma, mdat});
    endtask

    task automatic check_status(input string tag, input logic b, input logic h, input logic d,
                                input logic [3:0] f);
        check({tag, ".busy"},    {15'h0, busy},    {15'h0, b});
        check({tag, ".halted"},  {15'h0, halted},  {15'h0, h});
        check({tag, ".wb_done"}, {15'h0, wb_done}, {15'h0, d});
        check({tag, ".flags"},   {12'h0, flags_q}, {12'h0, f});
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 5'd0, 3'd0, 4'd0, 16'h0, 4'h0);
        step();
        step();
        check_ports("rst", 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 8'h00);
        check_status("rst", 1'b0, 1'b0, 1'b0, 4'h0);
        reset = 1'b0;

        // ADD rd=3, carry set
        drive(1'b1, 5'b00001, 3'd3, 4'h0, 16'h0042, 4'b0100);
        step();
        check_ports("add", 1'b1, 3'd3, 8'h42, 1'b0, 4'h0, 8'h00);
        check_status("add", 1'b0, 1'b0, 1'b1, 4'h0);
        drive(1'b0, 5'd0, 3'd0, 4'd0, 16'h0, 4'h0);
        step();
        check_ports("add_idle", 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 8'h00);
        check_status("add_idle", 1'b0, 1'b0, 1'b0, 4'b0100);

        // MUL rd=7 wraps high byte to reg 0; ADD offered while busy is dropped
        drive(1'b1, 5'b00011, 3'd7, 4'h0, 16'h1234, 4'b1011);
        step();
        check_ports("mul_lo", 1'b1, 3'd7, 8'h34, 1'b0, 4'h0, 8'h00);
        check_status("mul_lo", 1'b1, 1'b0, 1'b0, 4'b0100);
        drive(1'b1, 5'b00001, 3'd2, 4'h0, 16'h0055, 4'b0000);
        step();
        check_ports("mul_hi", 1'b1, 3'd0, 8'h12, 1'b0, 4'h0, 8'h00);
        check_status("mul_hi", 1'b0, 1'b0, 1'b1, 4'b1011);
        drive(1'b0, 5'd0, 3'd0, 4'd0, 16'h0, 4'h0);
        step();
        check_ports("mul_drop", 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 8'h00);
        check_status("mul_drop", 1'b0, 1'b0, 1'b0, 4'b1011);

        // Store: memory write only, flags untouched
        drive(1'b1, 5'b01100, 3'd5, 4'hA, 16'h00F0, 4'b0000);
        step();
        check_ports("store", 1'b0, 3'd0, 8'h00, 1'b1, 4'hA, 8'hF0);
        check_status("store", 1'b0, 1'b0, 1'b1, 4'b1011);
        drive(1'b0, 5'd0, 3'd0, 4'd0, 16'h0, 4'h0);
        step();
        check_status("store_after", 1'b0, 1'b0, 1'b0, 4'b1011);

        // Back-to-back ADD then AND
        drive(1'b1, 5'b00001, 3'd1, 4'h0, 16'h0011, 4'b1000);
        step();
        check_ports("b2b_add", 1'b1, 3'd1, 8'h11, 1'b0, 4'h0, 8'h00);
        check_status("b2b_add", 1'b0, 1'b0, 1'b1, 4'b1011);
        drive(1'b1, 5'b00110, 3'd5, 4'h0, 16'h0022, 4'b0100);
        step();
        check_ports("b2b_and", 1'b1, 3'd5, 8'h22, 1'b0, 4'h0, 8'h00);
        check_status("b2b_and", 1'b0, 1'b0, 1'b1, 4'b1000);

        // Jump follows directly: no writes, flags keep AND result
        drive(1'b1, 5'b01101, 3'd4, 4'h3, 16'h00AA, 4'b1111);
        step();
        check_ports("jump", 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 8'h00);
        check_status("jump", 1'b0, 1'b0, 1'b1, 4'b0100);
        drive(1'b0, 5'd0, 3'd0, 4'd0, 16'h0, 4'h0);
        step();
        check_status("jump_after", 1'b0, 1'b0, 1'b0, 4'b0100);

        // HALT then ADD: nothing retires
        drive(1'b1, 5'b11111, 3'd0, 4'h0, 16'h0000, 4'b0000);
        step();
        check_ports("halt", 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 8'h00);
        check_status("halt", 1'b1, 1'b1, 1'b0, 4'b0100);
        drive(1'b1, 5'b00001, 3'd6, 4'h0, 16'h0077, 4'b1111);
        step();
        step();
        check_ports("halt_add", 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 8'h00);
        check_status("halt_add", 1'b1, 1'b1, 1'b0, 4'b0100);

        // Reset wins over a held enable
        reset = 1'b1;
        step();
        check_ports("halt_rst", 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 8'h00);
        check_status("halt_rst", 1'b0, 1'b0, 1'b0, 4'h0);
        reset = 1'b0;
        drive(1'b0, 5'd0, 3'd0, 4'd0, 16'h0, 4'h0);
        step();
        check_status("post_rst", 1'b0, 1'b0, 1'b0, 4'h0);

        // Reset in the low-byte cycle of DIV discards the high-byte write
        drive(1'b1, 5'b00100, 3'd2, 4'h0, 16'hABCD, 4'b1111);
        step();
        check_ports("div_lo", 1'b1, 3'd2, 8'hCD, 1'b0, 4'h0, 8'h00);
        check_status("div_lo", 1'b1, 1'b0, 1'b0, 4'h0);
        drive(1'b0, 5'd0, 3'd0, 4'd0, 16'h0, 4'h0);
        reset = 1'b1;
        step();
        check_ports("div_rst", 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 8'h00);
        check_status("div_rst", 1'b0, 1'b0, 1'b0, 4'h0);
        reset = 1'b0;
        step();
        check_ports("div_after", 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 8'h00);
        check_status("div_after", 1'b0, 1'b0, 1'b0, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port enable, input, 1 bit: the execute-stage result is valid this cycle.
REQ-004 SHALL have port opcode, input, 5 bits: opcode of the instruction being retired.
REQ-005 SHALL have port rd, input, 3 bits: destination register address.
REQ-006 SHALL have port mem_addr, input, 4 bits: data-memory address for a store.
REQ-007 SHALL have port result, input, 16 bits: execute-stage result; bits [15:8] are meaningful only for MUL and DIV.
REQ-008 SHALL have ports zero_flag, carry_flag, ac_flag, parity_flag, input, 1 bit each: execute-stage flags.
REQ-009 SHALL have ports reg_we (output, 1), reg_waddr (output, 3) and reg_wdata (output, 8): register-file write port.
REQ-010 SHALL have ports mem_we (output, 1), mem_waddr (output, 4) and mem_wdata (output, 8): data-memory write port.
REQ-011 SHALL have port flags_q, output, 4 bits: architectural flags {zero, carry, ac, parity}.
REQ-012 SHALL have port busy, output, 1 bit: input not accepted this cycle.
REQ-013 SHALL have port halted, output, 1 bit: a HALT has retired.
REQ-014 SHALL have port wb_done, output, 1 bit: one-cycle pulse marking the final write cycle of an instruction.

Function
REQ-015 SHALL accept an instruction (latch opcode, rd, mem_addr, result and flags) on a clk edge where enable=1 and busy=0; enable while busy=1 SHALL be ignored, and upstream holds its inputs.
REQ-016 SHALL implement the states IDLE, COMMIT, WR_HI and HALT.
REQ-017 Transitions on accept:
- opcode 11111 -> HALT
- any other opcode -> COMMIT
REQ-018 Transitions with no accept:
- COMMIT, latched MUL (00011) or DIV (00100) -> WR_HI
- COMMIT, any other opcode -> IDLE
- WR_HI -> IDLE, or -> COMMIT on accept
- HALT -> HALT until reset
REQ-019 busy SHALL be 1 in HALT and in COMMIT when the latched opcode is MUL or DIV; busy SHALL be 0 otherwise.
REQ-020 In COMMIT, for opcodes 00000-01011 and 10000-10101 (excluding store 01100), the stage SHALL drive reg_we=1, reg_waddr=rd and reg_wdata=result[7:0].
REQ-021 In WR_HI the stage SHALL drive reg_we=1, reg_waddr=(rd+1) mod 8 (rd=7 wraps to 0) and reg_wdata=result[15:8].
REQ-022 In COMMIT, for store (01100), the stage SHALL drive mem_we=1, mem_waddr=mem_addr and mem_wdata=result[7:0], with reg_we=0.
REQ-023 Jump (01101), branches (01110, 10110, 10111, 11000), compare (11001) and undefined opcodes SHALL produce no register or memory write.
REQ-024 reg_we and mem_we SHALL never be 1 in the same cycle.
REQ-025 flags_q SHALL load the latched flags at the end of COMMIT for opcodes 00001-01010, 10000-10101 and 11001, and SHALL hold its value otherwise (including during WR_HI).
REQ-026 Latency: an instruction accepted at edge N SHALL write during the cycle after N; the high byte SHALL be written in the following cycle.
REQ-027 Throughput: single-write instructions SHALL sustain one per cycle back-to-back; a MUL or DIV SHALL occupy 2 cycles.
REQ-028 wb_done SHALL be 1 in COMMIT for non-MUL/DIV opcodes and in WR_HI, and 0 otherwise; halted SHALL be 1 exactly while in HALT.
REQ-029 All write-port outputs SHALL be 0 in IDLE and in HALT.

Reset
REQ-030 On reset=1 at a clk edge the state SHALL go to IDLE and all of the following SHALL be 0: reg_we, reg_waddr, reg_wdata, mem_we, mem_waddr, mem_wdata, flags_q, busy, halted, wb_done.
REQ-031 Reset SHALL take priority over enable, and a pending WR_HI write SHALL be discarded.
REQ-032 Reset SHALL be the only exit from HALT.

Verification
REQ-033 ADD retire: opcode=00001, rd=3, result=16'h0042, carry=1 -> next cycle reg_we=1, reg_waddr=3, reg_wdata=8'h42, wb_done=1; flags_q carry bit=1 afterwards.
REQ-034 MUL with rd=7 and result=16'h1234 -> cycle 1 writes reg 7 with 8'h34 and busy=1; cycle 2 writes reg 0 with 8'h12 and wb_done=1; enable held during cycle 1 is not accepted.
REQ-035 Store 01100, mem_addr=4'hA, result=16'h00F0 -> mem_we=1, mem_waddr=A, mem_wdata=F0, reg_we=0; flags_q unchanged.
REQ-036 Back-to-back ADD then AND on consecutive cycles -> writes on two consecutive cycles, busy stays 0.
REQ-037 HALT (11111) followed by an ADD with enable=1 -> halted=1, busy=1, no writes; reset then returns to IDLE with halted=0.
REQ-038 Reset asserted during the COMMIT cycle of a DIV -> no WR_HI write occurs and all outputs are 0 on the next cycle.
